edusoc_fetch_unit: RTL and testbench
====================================

Name: edusoc_fetch_unit

Overview:
Instruction fetch stage that drives the EduSoC instruction port (INSTR_REQ/INSTR_VALID/INSTR_ADDR/INSTR_RDATA) on the CPU_CLK/CPU_RES domain that edusoc_basic exports. It sequentially fetches 32-bit words from a program counter and buffers them in a small FIFO. It hands {pc, instr} pairs to the decode stage over a valid/ready handshake. Branch/jump redirects flush the buffer and restart fetching at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FIFO_DEPTH, 2, number of buffered instructions; power of two, 2..8.

Ports:
CPU_CLK  in  1  clock from edusoc_basic.
CPU_RES  in  1  synchronous reset, active-high, from edusoc_basic.
INSTR_REQ  out  1  fetch request to SoC.
INSTR_ADDR  out  32  fetch address; word-aligned, bits [1:0] always 0.
INSTR_VALID  in  1  SoC response strobe; one cycle per request.
INSTR_RDATA  in  32  fetched word; valid when INSTR_VALID=1.
REDIRECT  in  1  flush and restart request from execute stage.
REDIRECT_PC  in  32  new PC; bits [1:0] ignored and treated as 0.
OUT_VALID  out  1  head of FIFO holds an instruction.
OUT_READY  in  1  decode accepts the head entry.
OUT_INSTR  out  32  head instruction word.
OUT_PC  out  32  PC of head instruction.

Behaviour:
- Clock and reset: single clock CPU_CLK; CPU_RES is synchronous, active-high.
- Reset values: INSTR_REQ=0, INSTR_ADDR=RESET_PC, OUT_VALID=0, OUT_INSTR=0, OUT_PC=RESET_PC (head contents), fetch_pc=RESET_PC, FIFO count=0, state=IDLE. Reset overrides all other events, including an outstanding request; the bench must not return INSTR_VALID for a request killed by reset.
- SoC handshake:
  - INSTR_REQ is registered. Once asserted, INSTR_REQ and INSTR_ADDR stay stable until the cycle INSTR_VALID=1.
  - INSTR_VALID is sampled only while INSTR_REQ=1. Zero or more wait cycles are allowed.
  - At most one request is outstanding.
- States: IDLE, WAIT, DISCARD.
- IDLE:
  - If count<FIFO_DEPTH and REDIRECT=0: next cycle INSTR_REQ=1, INSTR_ADDR=fetch_pc, go to WAIT.
  - Space is checked against count only. The single outstanding response therefore always has a free slot, because pops only free slots.
- WAIT, on INSTR_VALID with no REDIRECT:
  - Push {fetch_pc, INSTR_RDATA}; fetch_pc += 4.
  - If count_after_push_and_pop<FIFO_DEPTH: stay in WAIT with INSTR_ADDR=fetch_pc+4 and INSTR_REQ held high (back-to-back fetch).
  - Otherwise: INSTR_REQ=0 next cycle, go to IDLE.
- WAIT, without INSTR_VALID: hold state, INSTR_REQ and INSTR_ADDR.
- REDIRECT (highest priority after reset):
  - FIFO flushed (count=0, OUT_VALID=0 next cycle); fetch_pc=REDIRECT_PC&~3.
  - Any push or pop in that cycle is suppressed.
  - From WAIT without same-cycle INSTR_VALID: go to DISCARD, keep INSTR_REQ and old INSTR_ADDR stable.
  - From WAIT with same-cycle INSTR_VALID: the data is dropped and the next request goes to the new PC, as in IDLE.
  - From IDLE or DISCARD: update fetch_pc only. DISCARD remains DISCARD.
- DISCARD: on INSTR_VALID, drop the data, INSTR_REQ=0 next cycle, go to IDLE. The first request to the redirected PC follows as defined in IDLE.
- Output side:
  - OUT_VALID = (count!=0); OUT_INSTR and OUT_PC are driven combinationally from the FIFO head register.
  - Pop on OUT_VALID & OUT_READY.
  - Simultaneous push and pop: count unchanged, order preserved.
- Latency: an instruction is visible on OUT_* the cycle after its INSTR_VALID. After reset deasserts, INSTR_REQ=1 on the first following cycle.
- Arithmetic: PC increment is 32-bit modulo, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
- FIFO pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package edusoc_fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, DISCARD};
  - XLEN=32;
  - PC_STEP=4;
  - fetch_entry_t struct {pc, instr}.
- Sub-module edusoc_fetch_fifo:
  - synchronous, parameterised depth;
  - push/pop/flush inputs, count and head outputs;
  - flush has priority over push/pop.

Test Plan:
1. Reset with RESET_PC=0x100, INSTR_VALID returned 1 cycle after each request, OUT_READY=1 → INSTR_ADDR sequence 0x100, 0x104, 0x108; OUT_PC and OUT_INSTR match 1 cycle after each INSTR_VALID; no gaps.
2. OUT_READY=0, FIFO_DEPTH=2 → exactly 2 responses accepted, then INSTR_REQ=0 and count=2. Raise OUT_READY for 1 cycle → one pop, new request to 0x108.
3. REDIRECT to 0x2002 while WAIT is outstanding for 0x104 with 3 wait cycles → INSTR_ADDR held at 0x104 until INSTR_VALID; its data is not output; next INSTR_ADDR=0x2000; OUT_VALID=0 the cycle after REDIRECT.
4. REDIRECT in the same cycle as INSTR_VALID and OUT_READY with count=1 → FIFO empty; the response is dropped; next request at the redirect PC; no extra pop recorded.
5. RESET_PC=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; OUT_PC matches.
6. Assert CPU_RES mid-WAIT → next cycle INSTR_REQ=0, OUT_VALID=0, INSTR_ADDR=RESET_PC; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/edusoc_fetch_pkg.sv
// Shared types for the EduSoC instruction fetch stage.
package edusoc_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/edusoc_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; head is visible the cycle after a push.
// Flush empties the buffer and wins over a same-cycle push or pop.
module edusoc_fetch_fifo
  import edusoc_fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             PW       = $clog2(DEPTH),
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: RESET_PC, instr: '0};
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/edusoc_fetch_unit.sv
// Sequential instruction fetch with one outstanding SoC request, buffered into a FIFO for decode.
// Redirects flush the buffer; a response still in flight at redirect time is discarded.
module edusoc_fetch_unit
  import edusoc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RES,
  output logic        INSTR_REQ,
  output logic [31:0] INSTR_ADDR,
  input  logic        INSTR_VALID,
  input  logic [31:0] INSTR_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_INSTR,
  output logic [31:0] OUT_PC
);

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  fetch_entry_t    head;
  fetch_entry_t    push_dat;
  logic            push;
  logic            pop;

  assign push       = (state == WAIT) && INSTR_VALID && !REDIRECT;
  assign pop        = OUT_VALID && OUT_READY && !REDIRECT;
  assign push_dat   = '{pc: fetch_pc, instr: INSTR_RDATA};
  assign count_next = count + CW'(push) - CW'(pop);

  assign OUT_VALID = (count != '0);
  assign OUT_INSTR = head.instr;
  assign OUT_PC    = head.pc;

  edusoc_fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .RESET_PC(RESET_PC)
  ) u_fifo (
    .clk     (CPU_CLK),
    .rst     (CPU_RES),
    .push    (push),
    .push_dat(push_dat),
    .pop     (pop),
    .flush   (REDIRECT),
    .count   (count),
    .head    (head)
  );

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RES) begin
      state      <= IDLE;
      INSTR_REQ  <= 1'b0;
      INSTR_ADDR <= RESET_PC;
      fetch_pc   <= RESET_PC;
    end else if (REDIRECT) begin
      fetch_pc <= REDIRECT_PC & ~32'd3;
      // A response landing with the redirect closes the request; otherwise keep it and drop it later.
      if (INSTR_REQ && INSTR_VALID) begin
        INSTR_REQ <= 1'b0;
        state     <= IDLE;
      end else if (state == WAIT) begin
        state <= DISCARD;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count < DEPTH_C) begin
            INSTR_REQ  <= 1'b1;
            INSTR_ADDR <= fetch_pc;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (INSTR_VALID) begin
            fetch_pc <= fetch_pc + PC_STEP;
            if (count_next < DEPTH_C) begin
              INSTR_ADDR <= fetch_pc + PC_STEP;
            end else begin
              INSTR_REQ <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (INSTR_VALID) begin
            INSTR_REQ <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edusoc_fetch_unit.sv
// Scoreboard bench for edusoc_fetch_unit with a variable-latency SoC responder and decode consumer.
module tb_edusoc_fetch_unit;
  import edusoc_fetch_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RES;
  logic        INSTR_REQ;
  logic [31:0] INSTR_ADDR;
  logic        INSTR_VALID;
  logic [31:0] INSTR_RDATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INSTR;
  logic [31:0] OUT_PC;

  always #5 CPU_CLK = ~CPU_CLK;

  edusoc_fetch_unit #(
    .RESET_PC  (RPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CPU_CLK    (CPU_CLK),
    .CPU_RES    (CPU_RES),
    .INSTR_REQ  (INSTR_REQ),
    .INSTR_ADDR (INSTR_ADDR),
    .INSTR_VALID(INSTR_VALID),
    .INSTR_RDATA(INSTR_RDATA),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_INSTR  (OUT_INSTR),
    .OUT_PC     (OUT_PC)
  );

  int n_tests = 0;
  int n_fail  = 0;

  fetch_entry_t sb[$];
  logic [31:0]  exp_addr;
  logic [31:0]  req_addr;
  logic [31:0]  redir_target;
  bit           outstanding, stale;
  bit           ready_en, rand_ready, redir_req, redir_on_give, hit4, saw_wrap;
  int           wcnt, lat;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic do_reset();
    CPU_RES     = 1'b1;
    INSTR_VALID = 1'b0;
    INSTR_RDATA = '0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;
    OUT_READY   = 1'b0;
    repeat (2) begin
      @(posedge CPU_CLK);
      #1;
    end
    sb.delete();
    outstanding = 0;
    stale       = 0;
    exp_addr    = RPC;
    CPU_RES     = 1'b0;
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model, step the clock.
  task automatic tick();
    bit           give, do_pop;
    fetch_entry_t e;
    expect_eq("out_vld", 32'(OUT_VALID), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      expect_eq("out_pc", OUT_PC, sb[0].pc);
      expect_eq("out_instr", OUT_INSTR, sb[0].instr);
      if (sb[0].pc == 32'h0) saw_wrap = 1;
    end
    if (INSTR_REQ) begin
      if (!outstanding) begin
        expect_eq("req_addr", INSTR_ADDR, exp_addr);
        expect_eq("req_room", 32'(sb.size() < DEPTH), 1);
        outstanding = 1;
        req_addr    = INSTR_ADDR;
        wcnt        = 0;
      end else begin
        expect_eq("addr_hold", INSTR_ADDR, req_addr);
      end
    end
    give = INSTR_REQ && (wcnt >= lat);
    if (INSTR_REQ && !give) wcnt++;
    OUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : ready_en;
    if (redir_on_give && give && sb.size() == 1) begin
      redir_req     = 1;
      OUT_READY     = 1'b1;
      redir_on_give = 0;
      hit4          = 1;
    end
    INSTR_VALID = give;
    INSTR_RDATA = give ? mem_word(INSTR_ADDR) : $urandom();
    REDIRECT    = redir_req;
    REDIRECT_PC = redir_target;
    do_pop = OUT_READY && (sb.size() != 0);
    if (redir_req) begin
      if (give) begin
        outstanding = 0;
        stale       = 0;
      end else if (INSTR_REQ) begin
        stale = 1;
      end
      sb.delete();
      exp_addr  = redir_target & ~32'd3;
      redir_req = 0;
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (give) begin
        if (!stale) begin
          e.pc    = exp_addr;
          e.instr = mem_word(exp_addr);
          sb.push_back(e);
          exp_addr = exp_addr + 32'd4;
        end
        outstanding = 0;
        stale       = 0;
      end
    end
    @(posedge CPU_CLK);
    #1;
  endtask

  initial begin
    lat = 0; ready_en = 0; rand_ready = 0; redir_req = 0; redir_on_give = 0;
    hit4 = 0; saw_wrap = 0; wcnt = 0; redir_target = '0; req_addr = '0;
    do_reset();
    expect_eq("rst_req", 32'(INSTR_REQ), 0);
    expect_eq("rst_vld", 32'(OUT_VALID), 0);
    expect_eq("rst_addr", INSTR_ADDR, RPC);
    expect_eq("rst_out_pc", OUT_PC, RPC);
    expect_eq("rst_out_instr", OUT_INSTR, 0);

    // Streaming with zero wait states: request goes up right after reset and never drops.
    lat = 0; ready_en = 1;
    tick();
    expect_eq("req_after_rst", 32'(INSTR_REQ), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_eq("b2b_req", 32'(INSTR_REQ), 1);
    end

    // Decode stalled: buffer fills to depth, fetch stops, one pop restarts it.
    ready_en = 0;
    repeat (6) tick();
    expect_eq("full_req", 32'(INSTR_REQ), 0);
    expect_eq("full_vld", 32'(OUT_VALID), 1);
    ready_en = 1;
    tick();
    ready_en = 0;
    tick();
    expect_eq("refetch_req", 32'(INSTR_REQ), 1);
    ready_en = 1;
    repeat (4) tick();

    // Redirect during a slow outstanding request.
    lat = 3;
    for (int i = 0; i < 40 && !(INSTR_REQ && outstanding && wcnt == 1); i++) tick();
    redir_req = 1; redir_target = 32'h0000_2002;
    tick();
    expect_eq("redir_flush", 32'(OUT_VALID), 0);
    expect_eq("redir_hold_req", 32'(INSTR_REQ), 1);
    repeat (20) tick();
    expect_eq("redir_progress", 32'(exp_addr > 32'h2000), 1);

    // Redirect coinciding with a response and a pop at count 1; target exercises PC wrap.
    lat = 1; ready_en = 0; redir_on_give = 1; redir_target = 32'hFFFF_FFF8;
    for (int i = 0; i < 40 && !hit4; i++) tick();
    expect_eq("same_cycle_hit", 32'(hit4), 1);
    expect_eq("same_cycle_flush", 32'(OUT_VALID), 0);
    lat = 0; ready_en = 1; saw_wrap = 0;
    repeat (8) tick();
    expect_eq("pc_wrap_seen", 32'(saw_wrap), 1);

    // Reset in the middle of a wait.
    lat = 3;
    for (int i = 0; i < 40 && !(INSTR_REQ && outstanding && wcnt == 2); i++) tick();
    do_reset();
    expect_eq("rst2_req", 32'(INSTR_REQ), 0);
    expect_eq("rst2_vld", 32'(OUT_VALID), 0);
    expect_eq("rst2_addr", INSTR_ADDR, RPC);
    lat = 0; ready_en = 1;
    repeat (6) tick();
    expect_eq("rst2_restart", 32'(exp_addr > RPC), 1);

    // Mixed traffic: random consumer, varying latency, occasional redirects.
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if (i % 10 == 0) lat = $urandom_range(0, 3);
      if (i % 37 == 36) begin
        redir_req    = 1;
        redir_target = $urandom();
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
